conv_1x1_accum: RTL and testbench



---
 rtl/conv_1x1_accum.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_conv_1x1_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_accum.sv
// conv_1x1_accum
//   Sums CHANNEL_NUM_IN fp products per pixel. Input arrives channel-major
//   (all IMAGE_SIZE pixels of channel 0, then channel 1, ...). Partial sums
//   live in an IMAGE_SIZE-deep RAM. Finished pixels are emitted in raster
//   order while the last channel streams in.
//
//   Optional feature macro: CONV_1X1_ACCUM_RELU_EN
//     defined   -> the output register applies ReLU (sign bit set -> +0.0;
//                  NaN passes through). RAM partial sums are never clamped.
//     undefined -> the raw sum is output.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     valid_in   pxl_in valid this cycle (no backpressure)
//     pxl_in     fp product from the upstream conv core
//     pxl_out    accumulated fp sum for one pixel
//     valid_out  one-cycle pulse per finished pixel
//     frame_done pulses with valid_out for the last pixel of the frame
//     busy       high from the first accepted input until frame_done
//
//   Files in this unit: fp_add (pipelined IEEE-754 binary32 adder, RNE),
//   conv_1x1_accum (top).

// fp_add
//   IEEE-754 binary32 adder, round-to-nearest-even, subnormals supported.
//   Any NaN input yields the canonical quiet NaN; inf - inf yields NaN.
//   The result is computed in one combinational step and then carried
//   through LATENCY registers, so valid_out follows valid_in by LATENCY.
//
//   Ports
//     clk, reset    clock, asynchronous active-low reset
//     valid_in      operands valid
//     a, b          binary32 operands
//     sum           binary32 result
//     valid_out     sum valid
module fp_add #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        valid_out
);

  function automatic logic [31:0] add_f32(input logic [31:0] op_a, input logic [31:0] op_b);
    logic        a_nan, b_nan, a_inf, b_inf, swap, sx, sy, sticky, rnd_up;
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] ax, ay, shifted, ay_al, norm;
    logic [27:0] raw;
    logic [9:0]  e;
    logic [24:0] rnd;

    a_nan = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    b_nan = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
    a_inf = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    b_inf = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
    res   = 32'd0;

    if (a_nan || b_nan) begin
      res = 32'h7FC0_0000;
    end else if (a_inf && b_inf) begin
      res = (op_a[31] == op_b[31]) ? op_a : 32'h7FC0_0000;
    end else if (a_inf) begin
      res = op_a;
    end else if (b_inf) begin
      res = op_b;
    end else begin
      // x is the larger magnitude so the aligned difference is never negative
      swap = (op_b[30:0] > op_a[30:0]);
      x    = swap ? op_b : op_a;
      y    = swap ? op_a : op_b;
      sx   = x[31];
      sy   = y[31];
      // subnormals use exponent 1 with no hidden bit
      ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx   = {(x[30:23] != 8'd0), x[22:0]};
      my   = {(y[30:23] != 8'd0), y[22:0]};
      d    = ex - ey;
      ax   = {mx, 3'b000};
      ay   = {my, 3'b000};

      // three extra bits (guard, round, sticky) below the mantissa
      if (d >= 8'd27) begin
        shifted = 27'd0;
        sticky  = (my != 24'd0);
      end else begin
        shifted = ay >> d;
        sticky  = ((ay & ((27'd1 << d) - 27'd1)) != 27'd0);
      end
      ay_al = {shifted[26:1], shifted[0] | sticky};

      raw = (sx == sy) ? ({1'b0, ax} + {1'b0, ay_al})
                       : ({1'b0, ax} - {1'b0, ay_al});
      e   = {2'b00, ex};

      if (raw == 28'd0) begin
        // exact cancellation gives +0 unless both operands were negative
        res = {sx & sy, 31'd0};
      end else begin
        if (raw[27]) begin
          norm = {raw[27:2], raw[1] | raw[0]};
          e    = e + 10'd1;
        end else begin
          norm = raw[26:0];
          for (int i = 0; i < 26; i++) begin
            if (!norm[26] && (e > 10'd1)) begin
              norm = norm << 1;
              e    = e - 10'd1;
            end
          end
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (rnd[24]) begin
          rnd = rnd >> 1;
          e   = e + 10'd1;
        end

        if (e >= 10'd255) begin
          res = {sx, 8'hFF, 23'd0};
        end else if (!rnd[23]) begin
          res = {sx, 8'h00, rnd[22:0]};
        end else begin
          res = {sx, e[7:0], rnd[22:0]};
        end
      end
    end
    return res;
  endfunction

  logic [LATENCY-1:0]       vld_pipe;
  logic [LATENCY-1:0][31:0] res_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= valid_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      res_pipe[0] <= add_f32(a, b);
    end
    for (int i = 1; i < LATENCY; i++) begin
      res_pipe[i] <= res_pipe[i-1];
    end
  end

  assign sum       = res_pipe[LATENCY-1];
  assign valid_out = vld_pipe[LATENCY-1];

endmodule

// Busy tracker states
//   state   | meaning
//   ST_IDLE | no frame in progress, waiting for the first input
//   ST_BUSY | frame in progress, until frame_done with no new input
module conv_1x1_accum #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 64,
  parameter int IMAGE_HEIGHT   = 64,
  parameter int CHANNEL_NUM_IN = 256,
  parameter int ADD_LATENCY    = 2,
  parameter int IMAGE_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int PXL_CNT_WIDTH  = $clog2(IMAGE_SIZE),
  parameter int CH_CNT_WIDTH   = $clog2(CHANNEL_NUM_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [PXL_CNT_WIDTH-1:0] PXL_LAST = PXL_CNT_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CH_CNT_WIDTH-1:0]  CH_LAST  = CH_CNT_WIDTH'(CHANNEL_NUM_IN - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t state, state_next;

  logic [PXL_CNT_WIDTH-1:0] pxl_cnt;
  logic [CH_CNT_WIDTH-1:0]  ch_cnt;

  logic                     s0_valid;
  logic [DATA_WIDTH-1:0]    s0_data;
  logic [PXL_CNT_WIDTH-1:0] s0_addr;
  logic                     s0_first;
  logic                     s0_last;

  logic [DATA_WIDTH-1:0]    ram [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]    rd_data;

  logic [DATA_WIDTH-1:0]    add_b;
  logic [DATA_WIDTH-1:0]    add_sum;
  logic                     add_valid;

  logic [ADD_LATENCY-1:0]                    sb_valid;
  logic [ADD_LATENCY-1:0]                    sb_last;
  logic [ADD_LATENCY-1:0][PXL_CNT_WIDTH-1:0] sb_addr;

  logic                     wb_valid;
  logic                     wb_last;
  logic [PXL_CNT_WIDTH-1:0] wb_addr;
  logic                     wb_we;
  logic [DATA_WIDTH-1:0]    out_word;

  // pixel / channel position of the next accepted input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_cnt <= '0;
      ch_cnt  <= '0;
    end else if (valid_in) begin
      if (pxl_cnt == PXL_LAST) begin
        pxl_cnt <= '0;
        ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
      end else begin
        pxl_cnt <= pxl_cnt + 1'b1;
      end
    end
  end

  // S0: capture the input alongside the RAM read of its partial sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_addr  <= '0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      s0_valid <= valid_in;
      if (valid_in) begin
        s0_data  <= pxl_in;
        s0_addr  <= pxl_cnt;
        s0_first <= (ch_cnt == '0);
        s0_last  <= (ch_cnt == CH_LAST);
      end
    end
  end

  // Same-address read and write are IMAGE_SIZE inputs apart, which exceeds
  // the writeback delay, so the read never needs a bypass.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      rd_data <= ram[pxl_cnt];
    end
    if (wb_we) begin
      ram[wb_addr] <= add_sum;
    end
  end

  // S1: channel 0 starts from +0.0 so stale RAM contents are ignored
  assign add_b = s0_first ? '0 : rd_data;

  fp_add #(
    .LATENCY (ADD_LATENCY)
  ) u_fp_add (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (s0_valid),
    .a         (s0_data),
    .b         (add_b),
    .sum       (add_sum),
    .valid_out (add_valid)
  );

  // sideband travels beside the adder so writeback knows where the sum goes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_valid <= '0;
      sb_last  <= '0;
      sb_addr  <= '0;
    end else begin
      sb_valid[0] <= s0_valid;
      sb_last[0]  <= s0_last;
      sb_addr[0]  <= s0_addr;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_last[i]  <= sb_last[i-1];
        sb_addr[i]  <= sb_addr[i-1];
      end
    end
  end

  assign wb_valid = sb_valid[ADD_LATENCY-1] & add_valid;
  assign wb_last  = sb_last[ADD_LATENCY-1];
  assign wb_addr  = sb_addr[ADD_LATENCY-1];
  assign wb_we    = wb_valid & ~wb_last;

`ifdef CONV_1X1_ACCUM_RELU_EN
  logic sum_nan;
  assign sum_nan  = (add_sum[30:23] == 8'hFF) && (add_sum[22:0] != 23'd0);
  assign out_word = (add_sum[DATA_WIDTH-1] && !sum_nan) ? '0 : add_sum;
`else
  assign out_word = add_sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= wb_valid & wb_last;
      frame_done <= wb_valid & wb_last & (wb_addr == PXL_LAST);
      if (wb_valid & wb_last) begin
        pxl_out <= out_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // an input arriving alongside frame_done starts the next frame at once
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (valid_in) state_next = ST_BUSY;
      ST_BUSY: if (frame_done && !valid_in) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: tb/tb_conv_1x1_accum.sv
module tb_conv_1x1_accum;

  localparam int IMG = 4;
  localparam int CH  = 3;
  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] pxl_out;
  logic        valid_out;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fd_stray;
  int busy_drop;

  logic [31:0] frame_vals [0:23];
  logic [31:0] out_q [$];
  int          out_cyc_q [$];
  bit          out_fd_q [$];
  int          last_cyc_q [$];

  conv_1x1_accum #(
    .DATA_WIDTH     (32),
    .IMAGE_WIDTH    (IMG),
    .IMAGE_HEIGHT   (1),
    .CHANNEL_NUM_IN (CH),
    .ADD_LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      out_q.push_back(pxl_out);
      out_cyc_q.push_back(cyc);
      out_fd_q.push_back(frame_done);
    end else if (frame_done) begin
      fd_stray++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_capture();
    out_q.delete();
    out_cyc_q.delete();
    out_fd_q.delete();
    fd_stray = 0;
  endtask

  // duty is the percent chance of presenting an input on a given cycle
  task automatic drive_frame(input int n, input int duty);
    int guard;
    last_cyc_q.delete();
    busy_drop = 0;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (duty < 100 && $urandom_range(0, 99) >= duty && guard < 50) begin
        @(negedge clk);
        if (i > 0 && !busy) busy_drop++;
        valid_in = 1'b0;
        pxl_in   = $urandom;
        guard++;
      end
      @(negedge clk);
      if (i > 0 && !busy) busy_drop++;
      valid_in = 1'b1;
      pxl_in   = frame_vals[i];
      if ((i / IMG) % CH == CH - 1) last_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int budget;
    budget = 0;
    while (out_q.size() < n && budget < 80) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: outputs seen %0d, required %0d", name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1'($urandom_range(0, 1));
      pxl_in   = $urandom;
    end
    @(negedge clk);
    checks++; if (pxl_out !== 32'd0)  begin errors++; $display("FAIL reset_pxl_out: got %h, want 00000000", pxl_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b, want 0", valid_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, want 0", frame_done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    valid_in = 1'b0;
    reset    = 1'b1;
    clear_capture();
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, want 0", busy); end
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL idle_outputs: got %0d, want 0", out_q.size()); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 12; i++) frame_vals[i] = 32'h3F80_0000;
    clear_capture();
    drive_frame(12, 100);
    wait_outputs(4, "basic");
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d, want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4 && i < last_cyc_q.size(); i++) begin
      checks++; if (out_q[i] !== 32'h4040_0000) begin errors++; $display("FAIL basic_value[%0d]: got %h, want 40400000", i, out_q[i]); end
      checks++; if (out_cyc_q[i] != last_cyc_q[i] + 4) begin errors++; $display("FAIL basic_latency[%0d]: got %0d, want %0d", i, out_cyc_q[i] - last_cyc_q[i], 4); end
      checks++; if (out_fd_q[i] !== (i == 3)) begin errors++; $display("FAIL basic_frame_done[%0d]: got %b, want %b", i, out_fd_q[i], (i == 3)); end
    end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL basic_busy_in_frame: low cycles %0d, want 0", busy_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, want 0", busy); end
    checks++; if (fd_stray != 0) begin errors++; $display("FAIL basic_stray_frame_done: got %0d, want 0", fd_stray); end
  endtask

  task automatic test_gapped();
    logic [31:0] v [0:7];
    logic [31:0] exp_sum [0:3];
    v = '{32'h0000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000,
          32'h4000_0000, 32'h4020_0000, 32'h4040_0000, 32'h4060_0000};
    exp_sum = '{32'h4040_0000, 32'h4090_0000, 32'h40C0_0000, 32'h40F0_0000};
    // value for channel c, pixel p is c + 0.5p, i.e. v[2c + p]
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < IMG; p++)
        frame_vals[c*IMG + p] = v[2*c + p];
    clear_capture();
    drive_frame(12, 30);
    wait_outputs(4, "gapped");
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL gapped_count: got %0d, want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4 && i < last_cyc_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_sum[i]) begin errors++; $display("FAIL gapped_value[%0d]: got %h, want %h", i, out_q[i], exp_sum[i]); end
      checks++; if (out_cyc_q[i] != last_cyc_q[i] + 4) begin errors++; $display("FAIL gapped_latency[%0d]: got %0d, want 4", i, out_cyc_q[i] - last_cyc_q[i]); end
      checks++; if (out_fd_q[i] !== (i == 3)) begin errors++; $display("FAIL gapped_frame_done[%0d]: got %b, want %b", i, out_fd_q[i], (i == 3)); end
    end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL gapped_busy_in_frame: low cycles %0d, want 0", busy_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gapped_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int i = 0; i < 12; i++)  frame_vals[i] = 32'h4000_0000;
    for (int i = 12; i < 24; i++) frame_vals[i] = 32'h3F80_0000;
    clear_capture();
    drive_frame(24, 100);
    wait_outputs(8, "b2b");
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL b2b_busy_boundary: low cycles %0d, want 0", busy_drop); end
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d, want 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8 && i < last_cyc_q.size(); i++) begin
      want = (i < 4) ? 32'h40C0_0000 : 32'h4040_0000;
      checks++; if (out_q[i] !== want) begin errors++; $display("FAIL b2b_value[%0d]: got %h, want %h", i, out_q[i], want); end
      checks++; if (out_cyc_q[i] != last_cyc_q[i] + 4) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d, want 4", i, out_cyc_q[i] - last_cyc_q[i]); end
      checks++; if (out_fd_q[i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_frame_done[%0d]: got %b, want %b", i, out_fd_q[i], (i == 3 || i == 7)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) frame_vals[i] = 32'h4000_0000;
    clear_capture();
    drive_frame(6, 100);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, want 0", busy); end
    checks++; if (pxl_out !== 32'd0) begin errors++; $display("FAIL mid_reset_pxl_out: got %h, want 00000000", pxl_out); end
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL mid_aborted_outputs: got %0d, want 0", out_q.size()); end
    for (int i = 0; i < 12; i++) frame_vals[i] = 32'h3F80_0000;
    clear_capture();
    drive_frame(12, 100);
    wait_outputs(4, "mid_frame_b");
    repeat (8) @(negedge clk);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL mid_b_count: got %0d, want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4 && i < last_cyc_q.size(); i++) begin
      checks++; if (out_q[i] !== 32'h4040_0000) begin errors++; $display("FAIL mid_b_value[%0d]: got %h, want 40400000", i, out_q[i]); end
      checks++; if (out_cyc_q[i] != last_cyc_q[i] + 4) begin errors++; $display("FAIL mid_b_latency[%0d]: got %0d, want 4", i, out_cyc_q[i] - last_cyc_q[i]); end
    end
  endtask

  task automatic test_relu();
    logic [31:0] want;
`ifdef CONV_1X1_ACCUM_RELU_EN
    want = 32'h0000_0000;
`else
    want = 32'hBF80_0000;
`endif
    for (int i = 0; i < 4; i++)  frame_vals[i] = 32'hC000_0000;
    for (int i = 4; i < 12; i++) frame_vals[i] = 32'h3F00_0000;
    clear_capture();
    drive_frame(12, 100);
    wait_outputs(4, "relu");
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL relu_count: got %0d, want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4; i++) begin
      checks++; if (out_q[i] !== want) begin errors++; $display("FAIL relu_value[%0d]: got %h, want %h", i, out_q[i], want); end
    end
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = 32'd0;
    fd_stray = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
